// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scanner with frame-synchronous display update and leading-zero blanking
module seg_scan_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic                  lzb_en,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  pending
);
    localparam int IW = $clog2(N_DIGITS);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t                state, nxt_state;
    logic [IW-1:0]         idx, nxt_idx;
    logic [15:0]           cnt, nxt_cnt;
    logic [4*N_DIGITS-1:0] disp, nxt_disp, pend_reg;
    logic                  boundary;
    logic [3:0]            digit;
    logic                  lz_blank;
    logic [6:0]            seg_d;
    logic [N_DIGITS-1:0]   an_d;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1111011;
            default: decode = 7'b0000001;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            disp     <= '0;
            pend_reg <= '0;
            pending  <= 1'b0;
            seg      <= '0;
            an       <= '0;
        end else begin
            state    <= nxt_state;
            idx      <= nxt_idx;
            cnt      <= nxt_cnt;
            disp     <= nxt_disp;
            pend_reg <= load && !boundary ? bcd_in : pend_reg;
            pending  <= boundary ? 1'b0 : load ? 1'b1 : pending;
            seg      <= seg_d;
            an       <= an_d;
        end
    end

    // The display register only moves on the last BLANK cycle of the last digit
    always_comb begin
        boundary  = en && state == BLANK && cnt == 16'(BLANK_CYCLES - 1) && idx == IW'(N_DIGITS - 1);
        nxt_disp  = !boundary ? disp : load ? bcd_in : pending ? pend_reg : disp;
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt + 16'd1;
        if (!en) begin
            nxt_state = IDLE;
            nxt_idx   = '0;
            nxt_cnt   = '0;
        end else if (state != SHOW && state != BLANK) begin
            nxt_state = SHOW;
            nxt_idx   = '0;
            nxt_cnt   = '0;
        end else if (state == SHOW && cnt == 16'(REFRESH_DIV - 1)) begin
            nxt_state = BLANK;
            nxt_cnt   = '0;
        end else if (state == BLANK && cnt == 16'(BLANK_CYCLES - 1)) begin
            nxt_state = SHOW;
            nxt_idx   = idx == IW'(N_DIGITS - 1) ? '0 : idx + 1'b1;
            nxt_cnt   = '0;
        end
    end

    // Outputs are decoded from next-state values so the registers line up with the state
    always_comb begin
        digit    = nxt_disp[{nxt_idx, 2'b00} +: 4];
        lz_blank = lzb_en && nxt_idx != '0 && (nxt_disp >> {nxt_idx, 2'b00}) == '0;
        an_d     = nxt_state == SHOW ? N_DIGITS'(1) << nxt_idx : '0;
        seg_d    = nxt_state == SHOW && !lz_blank ? decode(digit) : 7'd0;
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: table-driven frame checks with a per-cycle expected-output queue
module tb_seg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst, en, load, lzb_en;
    logic [15:0] bcd_in;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        pending;

    int errors = 0;
    int checks = 0;
    string tag;
    logic [11:0] exp_q[$];

    typedef struct {
        logic [15:0]     bcd;
        bit              lzb;
        logic [3:0][6:0] segs;
    } vec_t;

    vec_t vecs[7];

    seg_scan_ctrl #(.N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .bcd_in(bcd_in),
        .lzb_en(lzb_en), .seg(seg), .an(an), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        logic [11:0] e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({an, seg, pending} !== e) begin
            errors++;
            $display("FAIL %s t=%0t: an=%b seg=%b pending=%b, required an=%b seg=%b pending=%b",
                     tag, $time, an, seg, pending, e[11:8], e[7:1], e[0]);
        end
    endtask

    task automatic chk(input logic [3:0] a, input logic [6:0] s, input logic p);
        exp_q.push_back({a, s, p});
        tick();
    endtask

    // One scan frame (or its first n cycles), optionally with up to two loads at given cycles
    task automatic run_frame(input logic [3:0][6:0] s, input bit lz, input bit p0, input int n,
                             input int la, input logic [15:0] lb, input int la2,
                             input logic [15:0] lb2, input bit lp);
        bit p = p0;
        for (int t = 0; t < n; t++) begin
            lzb_en = lz;
            load   = (t == la) || (t == la2);
            bcd_in = t == la2 ? lb2 : lb;
            if (load) p = lp;
            chk(t % 6 < 4 ? 4'(1 << (t / 6)) : 4'b0, t % 6 < 4 ? s[t / 6] : 7'b0, p);
        end
        load = 1'b0;
    endtask

    initial begin
        vecs[0] = '{bcd: 16'h1234, lzb: 1'b0, segs: {7'h30, 7'h6D, 7'h79, 7'h33}};
        vecs[1] = '{bcd: 16'h0042, lzb: 1'b1, segs: {7'h00, 7'h00, 7'h33, 7'h6D}};
        vecs[2] = '{bcd: 16'h0000, lzb: 1'b1, segs: {7'h00, 7'h00, 7'h00, 7'h7E}};
        vecs[3] = '{bcd: 16'hABCD, lzb: 1'b0, segs: {7'h01, 7'h01, 7'h01, 7'h01}};
        vecs[4] = '{bcd: 16'h0042, lzb: 1'b0, segs: {7'h7E, 7'h7E, 7'h33, 7'h6D}};
        vecs[5] = '{bcd: 16'h9876, lzb: 1'b1, segs: {7'h7B, 7'h7F, 7'h70, 7'h5F}};
        vecs[6] = '{bcd: 16'h0500, lzb: 1'b1, segs: {7'h00, 7'h5B, 7'h7E, 7'h7E}};

        rst = 1'b1; en = 1'b0; load = 1'b0; lzb_en = 1'b0; bcd_in = '0;
        tag = "reset";
        chk(4'b0, 7'b0, 1'b0);
        chk(4'b0, 7'b0, 1'b0);
        rst = 1'b0;
        tag = "idle_load";
        load = 1'b1; bcd_in = 16'h1234;
        chk(4'b0, 7'b0, 1'b1);
        load = 1'b0;
        chk(4'b0, 7'b0, 1'b1);
        en = 1'b1;
        tag = "first_frame";
        run_frame({4{7'h7E}}, 1'b0, 1'b1, 24, -1, '0, -1, '0, 1'b0);
        tag = "frame_1234";
        run_frame(vecs[0].segs, vecs[0].lzb, 1'b0, 24, -1, '0, -1, '0, 1'b0);

        for (int i = 1; i < 7; i++) begin
            $sformat(tag, "vec%0d_load", i);
            run_frame(vecs[i-1].segs, vecs[i-1].lzb, 1'b0, 24, 10, vecs[i].bcd, -1, '0, 1'b1);
            $sformat(tag, "vec%0d_show", i);
            run_frame(vecs[i].segs, vecs[i].lzb, 1'b0, 24, -1, '0, -1, '0, 1'b0);
        end

        tag = "boundary_load";
        run_frame({4{7'h5B}}, 1'b0, 1'b0, 24, 0, 16'h5555, -1, '0, 1'b0);
        tag = "double_load";
        run_frame({4{7'h5B}}, 1'b0, 1'b0, 24, 3, 16'h1111, 15, 16'h2222, 1'b1);
        tag = "second_wins";
        run_frame({4{7'h6D}}, 1'b0, 1'b0, 24, -1, '0, -1, '0, 1'b0);

        tag = "en_drop";
        run_frame({4{7'h6D}}, 1'b0, 1'b0, 14, 5, 16'h0777, -1, '0, 1'b1);
        en = 1'b0;
        chk(4'b0, 7'b0, 1'b1);
        chk(4'b0, 7'b0, 1'b1);
        en = 1'b1;
        tag = "en_resume";
        run_frame({4{7'h6D}}, 1'b0, 1'b1, 24, -1, '0, -1, '0, 1'b0);
        tag = "frame_0777";
        run_frame({7'h00, 7'h70, 7'h70, 7'h70}, 1'b1, 1'b0, 24, -1, '0, -1, '0, 1'b0);

        tag = "rst_mid_blank";
        run_frame({7'h00, 7'h70, 7'h70, 7'h70}, 1'b1, 1'b0, 5, -1, '0, -1, '0, 1'b0);
        rst = 1'b1; load = 1'b1; bcd_in = 16'hFFFF;
        chk(4'b0, 7'b0, 1'b0);
        rst = 1'b0; load = 1'b0;
        tag = "after_rst";
        run_frame({4{7'h7E}}, 1'b0, 1'b0, 24, -1, '0, -1, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits, 2..8.
REQ-002 Parameter REFRESH_DIV, default 1000: clk cycles each digit is driven, 2..65535.
REQ-003 Parameter BLANK_CYCLES, default 8: anti-ghost gap between digits, 1..255.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 en  in  1  scan enable; 0 forces the display dark.
REQ-007 load  in  1  single-cycle strobe; bcd_in is valid when high.
REQ-008 bcd_in  in  4*N_DIGITS  packed BCD; digit 0 (least significant) in bits [3:0].
REQ-009 lzb_en  in  1  leading-zero blanking enable.
REQ-010 seg  out  7  segments abcdefg (bit 6 = a), active-high, registered.
REQ-011 an  out  N_DIGITS  digit enables, one-hot or zero, active-high, registered.
REQ-012 pending  out  1  high while a loaded value awaits frame-boundary transfer.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHOW and BLANK.
REQ-014 IDLE: an=0, seg=0; move to SHOW with digit index 0 on the cycle after en=1 is sampled.
REQ-015 SHOW: hold for exactly REFRESH_DIV cycles with an[idx]=1 and seg=decode(display[idx]), then go to BLANK.
REQ-016 BLANK: hold for exactly BLANK_CYCLES cycles with an=0 and seg=0, then advance idx and return to SHOW.
REQ-017 idx SHALL wrap from N_DIGITS-1 to 0; the BLANK-to-SHOW transition at this wrap is the frame boundary.
REQ-018 en=0 sampled in any state SHALL force IDLE on the next cycle and reset idx and the cycle counter to 0; display and pending contents are kept.
REQ-019 Decode SHALL be: 0-9 use standard abcdefg patterns (0=1111110, 1=0110000, 8=1111111, 9=1111011); values 10-15 give 0000001 (dash).
REQ-020 load=1 SHALL capture bcd_in into the pending register and set pending=1; a later load before transfer overwrites it.
REQ-021 At the frame boundary with pending=1: pending register is copied into the display register and pending clears in the same cycle.
REQ-022 A load on the frame-boundary cycle itself SHALL write bcd_in directly to the display register and leave pending=0.
REQ-023 The display register SHALL never change except at a frame boundary, so there is no tearing within a frame.
REQ-024 With lzb_en=1: a digit SHALL be blanked (seg=0, an still asserted) when it and every more-significant digit are 0; digit 0 is never blanked.
REQ-025 Output latency: seg and an SHALL reflect a state or idx change one clk after the transition decision; an and seg SHALL never show an illegal digit/pattern pairing.
REQ-026 Counters SHALL be sized for the parameter maximums and SHALL never overflow or skip.

Reset
REQ-027 On rst=1: state=IDLE, idx=0, counter=0, seg=0, an=0, pending=0, display register and pending register all zero.
REQ-028 rst SHALL take priority over en and load in the same cycle; a load coincident with rst is discarded.
REQ-029 rst asserted mid-SHOW or mid-BLANK SHALL darken outputs on the next cycle; scan restarts at digit 0 after rst=0 with en=1.

Verification (bench uses N_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2)
REQ-030 rst, then en=1, load bcd_in=16'h1234 while in IDLE -> after the first frame boundary, sequence an=0001/seg=0110011 (4) for 4 cycles, an=0 for 2 cycles, an=0010 (3), an=0100 (2), an=1000 (1); period 24 cycles.
REQ-031 load 16'h0042 mid-frame with lzb_en=1 -> pending=1 until the boundary; next frame digits 3 and 2 have seg=0 with an asserted, digit 1 shows 4, digit 0 shows 2.
REQ-032 load 16'h0000 with lzb_en=1 -> digit 0 shows 1111110 and digits 1-3 are blank.
REQ-033 load 16'hABCD -> all four digits show 0000001.
REQ-034 load 16'h5555 on the exact frame-boundary cycle -> display updates immediately, pending stays 0; two loads within one frame -> only the second is displayed.
REQ-035 en dropped mid-SHOW of digit 2 -> an=0 and seg=0 the next cycle; en restored -> scan resumes at digit 0 with unchanged display contents.
